maf_det: RTL and testbench
==========================

MAF_DET -- requirements
Module: maf_det

Interface
REQ-001 SHALL have parameter HOLD, default 3: consecutive qualifying samples needed to change level; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  input  8  moving-sum sample from the upstream averaging filter; one sample every cycle.
REQ-005 SHALL have port thr_hi  input  8  rise threshold; din >= thr_hi qualifies high.
REQ-006 SHALL have port thr_lo  input  8  fall threshold; din <= thr_lo qualifies low.
REQ-007 SHALL have port clr  input  1  synchronous clear of evt_cnt.
REQ-008 SHALL have port level  output  1  debounced hysteresis state.
REQ-009 SHALL have port rise  output  1  one-cycle pulse when level goes 0->1.
REQ-010 SHALL have port fall  output  1  one-cycle pulse when level goes 1->0.
REQ-011 SHALL have port peak  output  8  max din of the last completed high episode, held.
REQ-012 SHALL have port evt_cnt  output  8  saturating count of rise events.

Function
REQ-013 SHALL implement FSM with states LO, CONF_HI, HI, CONF_LO, plus a consecutive-sample counter cnt.
REQ-014 LO: din >= thr_hi -> CONF_HI with cnt=1, or directly HI if HOLD==1; otherwise stay in LO.
REQ-015 CONF_HI: din >= thr_hi -> cnt+1; on reaching HOLD -> HI; din < thr_hi -> LO, cnt=0.
REQ-016 HI: din <= thr_lo -> CONF_LO with cnt=1, or directly LO if HOLD==1; otherwise stay in HI.
REQ-017 CONF_LO: din <= thr_lo -> cnt+1; on reaching HOLD -> LO; din > thr_lo -> HI, cnt=0.
REQ-018 All outputs SHALL be registered; level/rise/fall update on the same edge that samples the HOLD-th qualifying din (latency HOLD edges from first qualifying sample).
REQ-019 rise and fall SHALL be high exactly one cycle per transition and never simultaneously.
REQ-020 Thresholds SHALL be sampled every cycle, unsigned; only the threshold relevant to the current state is compared, so thr_lo >= thr_hi requires no special handling.
REQ-021 Running max SHALL start at din on entry to CONF_HI and track max(din) through CONF_HI, HI, CONF_LO; an aborted CONF_HI discards it.
REQ-022 On the fall edge, peak SHALL load the running max, including samples seen in CONF_LO.
REQ-023 evt_cnt SHALL increment on each rise and saturate at 255.
REQ-024 clr SHALL zero evt_cnt; when clr and rise occur on the same edge, evt_cnt SHALL become 1 (event not lost).
REQ-025 din changing during CONF_* SHALL apply REQ-015/REQ-017 each cycle, with no memory of earlier aborted attempts.

Reset
REQ-026 reset low SHALL immediately force state LO, cnt=0, level=0, rise=0, fall=0, peak=0, evt_cnt=0, and clear the running max.
REQ-027 Reset asserted mid-episode SHALL produce no fall pulse; operation resumes from LO on the first edge after release.

Configuration
REQ-028 Macro MAF_DET_PEAK_EN SHALL select peak tracking: when defined, REQ-021/REQ-022 apply.
REQ-029 When MAF_DET_PEAK_EN is undefined, the running-max register SHALL be removed and peak SHALL be constant 0; all other behaviour is unchanged.

Verification (HOLD=3, thr_hi=100, thr_lo=60, MAF_DET_PEAK_EN defined)
REQ-030 din=50 x4, then 120,130,110,90 -> rise and level=1 on the edge sampling 110; no rise during 90.
REQ-031 din=120,130,70,120,120,120 -> no rise until the third 120 of the final run; evt_cnt=1.
REQ-032 In HI, din=55,150,40,30,20 -> level stays 1 through 150; fall on 20; peak=150.
REQ-033 Drive 257 rise episodes -> evt_cnt stops at 255; clr coinciding with the next rise -> evt_cnt=1.
REQ-034 reset low during CONF_LO of an episode -> level=0, peak=0, evt_cnt=0 immediately with no fall pulse; after release, din=200 x3 -> rise.
REQ-035 HOLD=1 build, din=100 then 60 -> rise on the first edge, fall on the next edge.

Source files
------------

// File: rtl/maf_det.sv
// maf_det: debounced hysteresis level detector on a moving-sum stream.
// Define MAF_DET_PEAK_EN to enable peak tracking; otherwise peak is 0.
module maf_det #(
    parameter int HOLD = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
    input  logic       clr,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] peak,
    output logic [7:0] evt_cnt
);

    localparam logic [3:0] HOLD_C = 4'(HOLD);

    typedef enum logic [1:0] {
        LO,
        CONF_HI,
        HI,
        CONF_LO
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] cnt_inc;
    logic       rise_nxt;
    logic       fall_nxt;
    logic       level_nxt;
    logic       q_hi;
    logic       q_lo;

    assign cnt_inc = cnt + 4'd1;
    assign q_hi    = (din >= thr_hi);
    assign q_lo    = (din <= thr_lo);

    // Next-state, confirm counter and edge pulses.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            LO: begin
                if (q_hi) begin
                    if (HOLD_C == 4'd1) begin
                        state_nxt = HI;
                        cnt_nxt   = 4'd0;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = CONF_HI;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            CONF_HI: begin
                if (q_hi) begin
                    if (cnt_inc >= HOLD_C) begin
                        state_nxt = HI;
                        cnt_nxt   = 4'd0;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = LO;
                    cnt_nxt   = 4'd0;
                end
            end
            HI: begin
                if (q_lo) begin
                    if (HOLD_C == 4'd1) begin
                        state_nxt = LO;
                        cnt_nxt   = 4'd0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = CONF_LO;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            CONF_LO: begin
                if (q_lo) begin
                    if (cnt_inc >= HOLD_C) begin
                        state_nxt = LO;
                        cnt_nxt   = 4'd0;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    state_nxt = HI;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = LO;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign level_nxt = (state_nxt == HI) || (state_nxt == CONF_LO);

    // State, counter and registered level/edge outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LO;
            cnt   <= 4'd0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Rise event counter; a clear on the rise edge still counts that rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_cnt <= 8'd0;
        end else if (clr) begin
            evt_cnt <= rise_nxt ? 8'd1 : 8'd0;
        end else if (rise_nxt && (evt_cnt != 8'hFF)) begin
            evt_cnt <= evt_cnt + 8'd1;
        end
    end

`ifdef MAF_DET_PEAK_EN
    logic [7:0] rmax;
    logic [7:0] rmax_cur;

    assign rmax_cur = (din > rmax) ? din : rmax;

    // Running max: seeded on episode entry, dropped whenever LO is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rmax <= 8'd0;
        end else if (state_nxt == LO) begin
            rmax <= 8'd0;
        end else if (state == LO) begin
            rmax <= din;
        end else begin
            rmax <= rmax_cur;
        end
    end

    // Peak of the episode is captured on its fall edge and held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak <= 8'd0;
        end else if (fall_nxt) begin
            peak <= rmax_cur;
        end
    end
`else
    assign peak = 8'd0;
`endif

endmodule

// File: tb/tb_maf_det.sv
// tb_maf_det: directed vectors for maf_det (HOLD=3 and HOLD=1).
// Peak expectations follow MAF_DET_PEAK_EN.
module tb_maf_det;

`ifdef MAF_DET_PEAK_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [7:0] din1;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic       clr;
    logic       level, rise, fall;
    logic [7:0] peak, evt_cnt;
    logic       level1, rise1, fall1;
    logic [7:0] peak1, evt_cnt1;

    int nvec = 0;
    int nerr = 0;

    maf_det #(.HOLD(3)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .thr_hi (thr_hi),
        .thr_lo (thr_lo),
        .clr    (clr),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .peak   (peak),
        .evt_cnt(evt_cnt)
    );

    maf_det #(.HOLD(1)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .din    (din1),
        .thr_hi (thr_hi),
        .thr_lo (thr_lo),
        .clr    (1'b0),
        .level  (level1),
        .rise   (rise1),
        .fall   (fall1),
        .peak   (peak1),
        .evt_cnt(evt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] v, input logic c = 1'b0);
        @(negedge clk);
        din = v;
        clr = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic step1(input logic [7:0] v);
        @(negedge clk);
        din1 = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        din    = 8'd0;
        din1   = 8'd0;
        thr_hi = 8'd100;
        thr_lo = 8'd60;
        clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_peak", peak, 0);
        check("rst_evt", evt_cnt, 0);
        @(negedge clk);
        reset = 1'b1;

        // rise on the third qualifying sample
        repeat (4) step(8'd50);
        check("a_lvl_lo", level, 0);
        step(8'd120);
        check("a_rise0", rise, 0);
        step(8'd130);
        check("a_lvl0", level, 0);
        step(8'd110);
        check("a_rise", rise, 1);
        check("a_lvl", level, 1);
        step(8'd90);
        check("a_rise_off", rise, 0);
        check("a_lvl_hold", level, 1);
        check("a_evt", evt_cnt, 1);
        step(8'd40);
        step(8'd40);
        check("a_fall0", fall, 0);
        step(8'd40);
        check("a_fall", fall, 1);
        check("a_lvl_off", level, 0);
        check("a_peak", peak, PK ? 130 : 0);

        // aborted confirm is forgotten
        step(8'd50, 1'b1);
        check("b_clr", evt_cnt, 0);
        step(8'd120);
        step(8'd130);
        step(8'd70);
        check("b_abort", level, 0);
        step(8'd120);
        step(8'd120);
        check("b_rise0", rise, 0);
        step(8'd120);
        check("b_rise", rise, 1);
        check("b_evt", evt_cnt, 1);

        // aborted fall confirm, then fall with new peak
        step(8'd55);
        check("c_lvl55", level, 1);
        step(8'd150);
        check("c_lvl150", level, 1);
        check("c_fall150", fall, 0);
        step(8'd40);
        step(8'd30);
        check("c_fall30", fall, 0);
        step(8'd20);
        check("c_fall", fall, 1);
        check("c_rise", rise, 0);
        check("c_peak", peak, PK ? 150 : 0);
        step(8'd20);
        check("c_fall_off", fall, 0);

        // saturation and clr coinciding with a rise
        step(8'd0, 1'b1);
        for (int e = 0; e < 257; e++) begin
            repeat (3) step(8'd200);
            repeat (3) step(8'd0);
            if (e == 253) check("d_evt254", evt_cnt, 254);
        end
        check("d_sat", evt_cnt, 255);
        step(8'd200);
        step(8'd200);
        step(8'd200, 1'b1);
        check("d_clr_rise", rise, 1);
        check("d_clr_evt", evt_cnt, 1);

        // async reset during fall confirm
        step(8'd30);
        step(8'd30);
        check("e_lvl_pre", level, 1);
        check("e_peak_pre", peak, PK ? 200 : 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("e_lvl", level, 0);
        check("e_peak", peak, 0);
        check("e_evt", evt_cnt, 0);
        check("e_fall", fall, 0);
        @(posedge clk);
        #1;
        check("e_fall_hold", fall, 0);
        @(negedge clk);
        reset = 1'b1;
        step(8'd200);
        step(8'd200);
        check("e_rise0", rise, 0);
        step(8'd200);
        check("e_rise", rise, 1);
        check("e_evt1", evt_cnt, 1);

        // HOLD=1 with inputs on the thresholds
        step1(8'd100);
        check("f_rise", rise1, 1);
        check("f_lvl", level1, 1);
        step1(8'd60);
        check("f_fall", fall1, 1);
        check("f_rise_off", rise1, 0);
        check("f_lvl_off", level1, 0);
        check("f_peak", peak1, PK ? 100 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
